riscv_fetch_queue: RTL and testbench
====================================

RISCV_FETCH_QUEUE -- requirements
Module: riscv_fetch_queue

Interface
REQ-001 SHALL have parameter XLEN, default 32, address/PC width.
REQ-002 SHALL have parameter DEPTH, default 4, queue entries and maximum credits; power of two, at least 2.
REQ-003 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address.
REQ-004 SHALL have port clk_i, input, 1, single clock, rising edge.
REQ-005 SHALL have port rstn_i, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port redirect_i, input, 1, flush plus PC redirect from execute (taken branch or jump).
REQ-007 SHALL have port redirect_pc_i, input, XLEN, redirect target.
REQ-008 SHALL have port imem_req_o, output, 1, instruction memory request.
REQ-009 SHALL have port imem_addr_o, output, XLEN, request address.
REQ-010 SHALL have port imem_gnt_i, input, 1, request accepted.
REQ-011 SHALL have port imem_rvalid_i, input, 1, in-order response valid, latency of 1 or more cycles.
REQ-012 SHALL have port imem_rdata_i, input, 32, response instruction.
REQ-013 SHALL have port dec_valid_o, output, 1, head entry valid toward decode.
REQ-014 SHALL have port dec_ready_i, input, 1, decode not stalled.
REQ-015 SHALL have port dec_pc_o, output, XLEN, PC of head entry.
REQ-016 SHALL have port dec_instr_o, output, 32, instruction of head entry.

Function
REQ-017 SHALL hold fetch_pc and resp_pc registers, both RESET_PC at reset, each advancing by 4 (mod 2^XLEN) on accepted request and on kept response respectively.
REQ-018 SHALL assert imem_req_o iff count + outstanding < DEPTH and redirect_i = 0; imem_addr_o = fetch_pc with bits [1:0] = 0.
REQ-019 SHALL treat imem_req_o && imem_gnt_i as an issued request: outstanding + 1, fetch_pc + 4.
REQ-020 SHALL, on imem_rvalid_i with discard_cnt = 0, push {resp_pc, imem_rdata_i} at the tail and decrement outstanding.
REQ-021 SHALL, on imem_rvalid_i with discard_cnt > 0, drop the data and decrement both discard_cnt and outstanding.
REQ-022 SHALL drive dec_valid_o = (count != 0) && !redirect_i, with dec_pc_o/dec_instr_o taken from the head entry.
REQ-023 SHALL pop the head on dec_valid_o && dec_ready_i; head and tail pointers wrap modulo DEPTH.
REQ-024 SHALL keep count unchanged on a simultaneous push and pop, including when count = DEPTH-1 or count = 1.
REQ-025 SHALL have no empty-queue bypass: pushed data appears on dec_valid_o the cycle after imem_rvalid_i.
REQ-026 SHALL, in a redirect_i cycle: issue no request, clear the queue (count = 0, head = tail), load fetch_pc and resp_pc with {redirect_pc_i[XLEN-1:2], 2'b00}, and set discard_cnt = outstanding at that cycle's end, where any same-cycle rvalid is itself discarded.
REQ-027 SHALL, on a redirect while discard_cnt > 0, accumulate the count so that every pre-redirect response is dropped.
REQ-028 SHALL, by construction of the credit count, never push into a full queue and never see outstanding exceed DEPTH.

Reset
REQ-029 SHALL, while rstn_i = 0, asynchronously force imem_req_o = 0, dec_valid_o = 0, dec_pc_o = 0, dec_instr_o = 0, count = outstanding = discard_cnt = 0, pointers = 0, and fetch_pc = resp_pc = RESET_PC.
REQ-030 SHALL assert imem_req_o in the first clock after rstn_i deasserts.
REQ-031 SHALL ignore memory responses to requests issued before a mid-operation reset; the memory side is reset on the same rstn_i.

Configuration
REQ-032 SHALL, with macro RISCV_FETCH_STATS_EN defined, add output stat_issued_o (32) and output stat_discarded_o (32), counting issued requests and dropped responses; both reset to 0 and wrap at 2^32.
REQ-033 SHALL, with RISCV_FETCH_STATS_EN undefined, contain neither port nor counter logic; all other behaviour is identical.

Verification
REQ-034 Reset with RESET_PC = 0x100, gnt = 1, 1-cycle rvalid, dec_ready_i = 1 -> dec_pc_o runs 0x100, 0x104, 0x108 on consecutive cycles, first dec_valid_o two cycles after the first request.
REQ-035 dec_ready_i = 0, DEPTH = 4 -> exactly 4 requests issued, then imem_req_o = 0; one pop -> exactly one new request.
REQ-036 Redirect to 0x203 with 2 responses in flight -> next imem_addr_o = 0x200; the 2 late responses are dropped; first dec_pc_o = 0x200.
REQ-037 Second redirect to 0x400 while discard_cnt = 1 and 1 new request outstanding -> both are dropped; first dec_pc_o = 0x400.
REQ-038 rstn_i pulsed low mid-stream with 3 entries queued -> outputs zero immediately; after release fetch restarts at RESET_PC.
REQ-039 With RISCV_FETCH_STATS_EN, scenario REQ-036 -> stat_discarded_o = 2 and stat_issued_o = number of grants.

Source files
------------

// File: rtl/riscv_fetch_queue.sv
// Credit-based instruction fetch queue: issues in-order memory requests and buffers responses for decode.
// Optional request/discard statistics counters are built in when RISCV_FETCH_STATS_EN is defined.
module riscv_fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [31:0]     imem_rdata_i,
    output logic            dec_valid_o,
    input  logic            dec_ready_i,
    output logic [XLEN-1:0] dec_pc_o,
    output logic [31:0]     dec_instr_o
`ifdef RISCV_FETCH_STATS_EN
    ,
    output logic [31:0]     stat_issued_o,
    output logic [31:0]     stat_discarded_o
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0]     DEPTH_W    = (CW+1)'(DEPTH);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(3));

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] resp_pc;
    logic [CW-1:0]   count;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   outstanding_nxt;
    logic [CW-1:0]   discard_cnt;
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [31:0]     instr_mem [DEPTH];

    logic [CW:0]     in_use;
    logic            issue;
    logic            rsp_drop;
    logic            push;
    logic            pop;
    logic [XLEN-1:0] redirect_base;

    // Queued entries plus in-flight requests form the credit pool, so the queue can never overflow.
    assign in_use        = {1'b0, count} + {1'b0, outstanding};
    assign imem_req_o    = rstn_i && !redirect_i && (in_use < DEPTH_W);
    assign imem_addr_o   = fetch_pc & ALIGN_MASK;
    assign redirect_base = redirect_pc_i & ALIGN_MASK;

    assign issue    = imem_req_o && imem_gnt_i;
    assign rsp_drop = imem_rvalid_i && (redirect_i || (discard_cnt != '0));
    assign push     = imem_rvalid_i && !rsp_drop;

    assign dec_valid_o = (count != '0) && !redirect_i;
    assign dec_pc_o    = pc_mem[head];
    assign dec_instr_o = instr_mem[head];
    assign pop         = dec_valid_o && dec_ready_i;

    always_comb begin
        outstanding_nxt = outstanding;
        if (issue && !imem_rvalid_i) begin
            outstanding_nxt = outstanding + CW'(1);
        end else if (!issue && imem_rvalid_i) begin
            outstanding_nxt = outstanding - CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            count       <= '0;
            outstanding <= '0;
            discard_cnt <= '0;
            head        <= '0;
            tail        <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]    <= '0;
                instr_mem[i] <= '0;
            end
        end else begin
            outstanding <= outstanding_nxt;
            if (redirect_i) begin
                // Everything still in flight predates the redirect, including earlier discards.
                fetch_pc    <= redirect_base;
                resp_pc     <= redirect_base;
                count       <= '0;
                head        <= '0;
                tail        <= '0;
                discard_cnt <= outstanding_nxt;
            end else begin
                if (issue) begin
                    fetch_pc <= fetch_pc + XLEN'(4);
                end
                if (push) begin
                    pc_mem[tail]    <= resp_pc;
                    instr_mem[tail] <= imem_rdata_i;
                    tail            <= tail + PW'(1);
                    resp_pc         <= resp_pc + XLEN'(4);
                end
                if (pop) begin
                    head <= head + PW'(1);
                end
                if (push && !pop) begin
                    count <= count + CW'(1);
                end else if (pop && !push) begin
                    count <= count - CW'(1);
                end
                if (rsp_drop) begin
                    discard_cnt <= discard_cnt - CW'(1);
                end
            end
        end
    end

`ifdef RISCV_FETCH_STATS_EN
    logic [31:0] stat_issued;
    logic [31:0] stat_discarded;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            stat_issued    <= '0;
            stat_discarded <= '0;
        end else begin
            if (issue) begin
                stat_issued <= stat_issued + 32'd1;
            end
            if (rsp_drop) begin
                stat_discarded <= stat_discarded + 32'd1;
            end
        end
    end

    assign stat_issued_o    = stat_issued;
    assign stat_discarded_o = stat_discarded;
`endif

endmodule

// File: tb/tb_riscv_fetch_queue.sv
// Bench for riscv_fetch_queue: directed scenarios then random traffic against a queue-based reference model.
// Stats port checks are compiled in when RISCV_FETCH_STATS_EN is defined.
module tb_riscv_fetch_queue;

    localparam int          XLEN  = 32;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0000_0100;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        dec_valid_o;
    logic        dec_ready_i;
    logic [31:0] dec_pc_o;
    logic [31:0] dec_instr_o;
`ifdef RISCV_FETCH_STATS_EN
    logic [31:0] stat_issued_o;
    logic [31:0] stat_discarded_o;
`endif

    riscv_fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk_i         (clk_i),
        .rstn_i        (rstn_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .dec_valid_o   (dec_valid_o),
        .dec_ready_i   (dec_ready_i),
        .dec_pc_o      (dec_pc_o),
        .dec_instr_o   (dec_instr_o)
`ifdef RISCV_FETCH_STATS_EN
        ,
        .stat_issued_o    (stat_issued_o),
        .stat_discarded_o (stat_discarded_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mem_t;

    mem_t        mem_q[$];
    logic [31:0] m_q[$];
    logic [31:0] m_fetch_pc;
    logic [31:0] m_resp_pc;
    int          m_out;
    int          m_disc;
    int          m_issued;
    int          m_dropped;
    int          cyc;
    int          total;
    int          bad;

    logic        obs_req;
    logic [31:0] obs_addr;
    logic        obs_dv;
    logic [31:0] obs_pc;
    logic        obs_gnt;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h1357_9bdf;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs mid-cycle, compare outputs to the model, then advance the model.
    task automatic step(input logic redir, input logic [31:0] rpc, input logic gnt,
                        input logic rdy, input int lat);
        logic        rv;
        logic        exp_req;
        logic        exp_dv;
        @(negedge clk_i);
        rv            = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
        redirect_i    = redir;
        redirect_pc_i = rpc;
        imem_gnt_i    = gnt;
        dec_ready_i   = rdy;
        imem_rvalid_i = rv;
        imem_rdata_i  = rv ? instr_of(mem_q[0].addr) : $urandom;
        #1;
        obs_req  = imem_req_o;
        obs_addr = imem_addr_o;
        obs_dv   = dec_valid_o;
        obs_pc   = dec_pc_o;
        obs_gnt  = gnt;
        exp_req  = ((m_q.size() + m_out) < DEPTH) && !redir;
        exp_dv   = (m_q.size() != 0) && !redir;
        check("req", {31'd0, imem_req_o}, {31'd0, exp_req});
        if (exp_req) check("addr", imem_addr_o, m_fetch_pc);
        check("dec_valid", {31'd0, dec_valid_o}, {31'd0, exp_dv});
        if (exp_dv) begin
            check("dec_pc", dec_pc_o, m_q[0]);
            check("dec_instr", dec_instr_o, instr_of(m_q[0]));
        end
`ifdef RISCV_FETCH_STATS_EN
        check("stat_issued", stat_issued_o, m_issued);
        check("stat_discarded", stat_discarded_o, m_dropped);
`endif
        if (exp_dv && rdy) void'(m_q.pop_front());
        if (rv) begin
            void'(mem_q.pop_front());
            m_out--;
            if (redir || m_disc > 0) begin
                if (!redir) m_disc--;
                m_dropped++;
            end else begin
                m_q.push_back(m_resp_pc);
                m_resp_pc += 4;
            end
        end
        if (exp_req && gnt) begin
            mem_q.push_back('{addr: m_fetch_pc, due: cyc + lat});
            m_out++;
            m_issued++;
            m_fetch_pc += 4;
        end
        if (redir) begin
            m_q.delete();
            m_fetch_pc = {rpc[31:2], 2'b00};
            m_resp_pc  = {rpc[31:2], 2'b00};
            m_disc     = m_out;
        end
        cyc++;
    endtask

    // Async reset asserted mid-cycle; memory side resets alongside, so in-flight responses vanish.
    task automatic do_reset();
        @(negedge clk_i);
        rstn_i        = 1'b0;
        redirect_i    = 1'b0;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        dec_ready_i   = 1'b0;
        #1;
        check("rst_req", {31'd0, imem_req_o}, 32'd0);
        check("rst_valid", {31'd0, dec_valid_o}, 32'd0);
        check("rst_pc", dec_pc_o, 32'd0);
        check("rst_instr", dec_instr_o, 32'd0);
        mem_q.delete();
        m_q.delete();
        m_fetch_pc = RPC;
        m_resp_pc  = RPC;
        m_out      = 0;
        m_disc     = 0;
        m_issued   = 0;
        m_dropped  = 0;
        repeat (2) @(posedge clk_i);
        #1 rstn_i = 1'b1;
    endtask

    task automatic first_pc(input string tag, input logic [31:0] exp);
        logic        found;
        logic [31:0] pc;
        found = 1'b0;
        pc    = 32'hffff_ffff;
        for (int i = 0; i < 16 && !found; i++) begin
            step(1'b0, 32'd0, 1'b1, 1'b1, 1);
            if (obs_dv) begin
                found = 1'b1;
                pc    = obs_pc;
            end
        end
        check(tag, pc, exp);
    endtask

    // Two requests in flight (latency 3 and 4), then redirect to 0x203.
    task automatic two_in_flight_redirect();
        step(1'b0, 32'd0, 1'b1, 1'b1, 3);
        step(1'b0, 32'd0, 1'b1, 1'b1, 4);
        step(1'b1, 32'h0000_0203, 1'b1, 1'b1, 1);
    endtask

    initial begin
        int grants;
        total         = 0;
        bad           = 0;
        cyc           = 0;
        rstn_i        = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
        dec_ready_i   = 1'b0;

        // Streaming after reset: request in first cycle, decode sees 0x100 two cycles later.
        do_reset();
        step(1'b0, 32'd0, 1'b1, 1'b1, 1);
        check("first_req", {31'd0, obs_req}, 32'd1);
        check("first_addr", obs_addr, RPC);
        step(1'b0, 32'd0, 1'b1, 1'b1, 1);
        check("no_bypass", {31'd0, obs_dv}, 32'd0);
        step(1'b0, 32'd0, 1'b1, 1'b1, 1);
        check("stream0", obs_dv ? obs_pc : 32'hffff_ffff, 32'h100);
        step(1'b0, 32'd0, 1'b1, 1'b1, 1);
        check("stream1", obs_dv ? obs_pc : 32'hffff_ffff, 32'h104);
        step(1'b0, 32'd0, 1'b1, 1'b1, 1);
        check("stream2", obs_dv ? obs_pc : 32'hffff_ffff, 32'h108);

        // Decode stalled: credits cap issue at DEPTH, one pop frees exactly one.
        do_reset();
        grants = 0;
        repeat (8) begin
            step(1'b0, 32'd0, 1'b1, 1'b0, 1);
            if (obs_req && obs_gnt) grants++;
        end
        check("stall_grants", grants, DEPTH);
        grants = 0;
        step(1'b0, 32'd0, 1'b1, 1'b1, 1);
        if (obs_req && obs_gnt) grants++;
        repeat (6) begin
            step(1'b0, 32'd0, 1'b1, 1'b0, 1);
            if (obs_req && obs_gnt) grants++;
        end
        check("pop_grants", grants, 1);

        // Redirect with two responses in flight.
        do_reset();
        two_in_flight_redirect();
        step(1'b0, 32'd0, 1'b1, 1'b1, 1);
        check("redir_req", {31'd0, obs_req}, 32'd1);
        check("redir_addr", obs_addr, 32'h200);
        first_pc("redir_first_pc", 32'h200);
`ifdef RISCV_FETCH_STATS_EN
        check("stat_disc_2", stat_discarded_o, 32'd2);
`endif

        // Second redirect while one discard and one new request are pending.
        do_reset();
        two_in_flight_redirect();
        step(1'b0, 32'd0, 1'b1, 1'b1, 3);
        step(1'b1, 32'h0000_0400, 1'b1, 1'b1, 1);
        first_pc("redir2_first_pc", 32'h400);

        // Reset pulse mid-stream with entries queued.
        do_reset();
        repeat (4) step(1'b0, 32'd0, 1'b1, 1'b0, 1);
        check("pre_rst_valid", {31'd0, obs_dv}, 32'd1);
        do_reset();
        step(1'b0, 32'd0, 1'b1, 1'b1, 1);
        check("restart_req", {31'd0, obs_req}, 32'd1);
        check("restart_addr", obs_addr, RPC);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 15) == 0, $urandom, $urandom_range(0, 3) != 0,
                     $urandom_range(0, 3) != 0, $urandom_range(1, 4));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
